// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end feeding the IF/ID register.
//
// Owns the fetch PC, issues in-order requests to a req/gnt/rvalid
// instruction memory and keeps up to DEPTH fetches (issued or returned) in
// a circular queue. Entries are filled strictly in order, so the filled
// entries always form a prefix starting at the head; fcnt counts that
// prefix and the oldest unfilled entry sits at head + fcnt.
// A redirect flushes the queue and turns every still-outstanding response
// into a "discard" credit so stale data never lands in the new stream.
//
// Optional feature (macro FETCH_BYPASS_EN): a response for an unfilled
// head is presented combinationally in the cycle it arrives.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   StallF                hold the presented instruction
//   PCSrcE, PCTargetE     redirect request and target
//   imem_req/addr/gnt     request channel to instruction memory
//   imem_rvalid/rdata     in-order response channel
//   PCF, PCPlus4F, InstrF presented fetch triple (NOP when not valid)
//   InstrValidF           InstrF holds a real fetched instruction
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic [31:0]     InstrF,
    output logic            InstrValidF
);
    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  q_pc   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_filled;
    logic [PW-1:0]    head, tail, fptr;
    logic [CW-1:0]    count, fcnt, discard, unfilled;
    logic [CW:0]      dsum;
    logic [CW-1:0]    discard_redir;

    logic empty, full, head_filled, resp_take, byp, push, pop, store;
    logic unused_bits;

    // The target's low bits are forced to a word boundary.
    assign unused_bits = ^PCTargetE[1:0];

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign unfilled    = count - fcnt;
    assign fptr        = head + PW'(fcnt);
    assign head_filled = !empty && q_filled[head];

    // A response is only usable when it is not owed to a pre-redirect
    // request and there is an entry waiting for it; anything else is dropped.
    assign resp_take   = imem_rvalid && (discard == '0) && (unfilled != '0);

`ifdef FETCH_BYPASS_EN
    // Oldest unfilled entry is the head exactly when no entry is filled.
    assign byp = resp_take && (fcnt == '0);
`else
    assign byp = 1'b0;
`endif

    assign imem_req    = rst_n && !full && !PCSrcE;
    assign imem_addr   = pc_q;
    assign push        = imem_req && imem_gnt;
    assign InstrValidF = head_filled || byp;
    assign pop         = InstrValidF && !StallF;
    // A bypassed instruction that is consumed immediately never gets stored.
    assign store       = resp_take && !(byp && pop);

    assign PCF      = empty ? pc_q : q_pc[head];
    assign PCPlus4F = PCF + XLEN'(4);
    assign InstrF   = head_filled ? q_data[head] :
                      byp         ? imem_rdata   : INSTR_NOP;

    // Outstanding responses still owed after a flush; the one arriving in
    // the redirect cycle itself is dropped here, hence the decrement.
    always_comb begin
        dsum = {1'b0, discard} + {1'b0, unfilled};
        if (imem_rvalid && dsum != '0)
            dsum = dsum - 1'b1;
        discard_redir = CW'(dsum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fcnt     <= '0;
            discard  <= '0;
            q_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else if (PCSrcE) begin
            pc_q     <= {PCTargetE[XLEN-1:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fcnt     <= '0;
            q_filled <= '0;
            discard  <= discard_redir;
        end else begin
            if (push) begin
                q_pc[tail]     <= pc_q;
                q_filled[tail] <= 1'b0;
                tail           <= tail + 1'b1;
                pc_q           <= pc_q + XLEN'(4);
            end
            if (store) begin
                q_data[fptr]   <= imem_rdata;
                q_filled[fptr] <= 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            fcnt  <= fcnt + CW'(resp_take) - CW'(pop);
            if (imem_rvalid && discard != '0)
                discard <= discard - 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the memory model pushes {addr, data}
// on every grant, a monitor pops and compares on every consume, and the
// directed sequence checks reset, stall, gnt-low, redirect and latency.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk, rst_n, StallF, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PCF, PCPlus4F, InstrF;
    logic        InstrValidF;

    exp_t        exp_q[$];
    logic [31:0] pend[$];
    logic [31:0] grant_log[$];
    logic [31:0] tb_pc;
    logic        mem_hold;
    logic        m_g;
    logic [31:0] m_a;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .InstrValidF(InstrValidF)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] epc);
        int n = 0;
        @(negedge clk);
        while (!InstrValidF && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!InstrValidF) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout waiting for valid, got pc %h expected %h", name, PCF, epc);
        end else begin
            chk({name, "_pc"}, PCF, epc);
            chk({name, "_instr"}, InstrF, mdata(epc));
        end
    endtask

    // 1-cycle in-order memory: grant seen mid-cycle, response next cycle.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            m_g = imem_req && imem_gnt;
            m_a = imem_addr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend.delete();
            end else if (m_g) begin
                pend.push_back(m_a);
                exp_q.push_back('{pc: m_a, data: mdata(m_a)});
                grant_log.push_back(m_a);
                tb_pc = m_a + 32'd4;
            end
            if (rst_n && pend.size() > 0 && !mem_hold) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mdata(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    // Monitor: every consumed instruction must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && InstrValidF && !StallF && !PCSrcE) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL consume: unexpected instr at pc %h, expected none", PCF);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pcf", PCF, e.pc);
                    chk("mon_instr", InstrF, e.data);
                    chk("mon_pcplus4", PCPlus4F, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        rst_n = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem_gnt = 1'b0; mem_hold = 1'b0; tb_pc = RST_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_pcf", PCF, RST_PC);
        chk("rst_pcplus4", PCPlus4F, RST_PC + 32'd4);
        chk("rst_instr", InstrF, NOP);
        chk("rst_valid", InstrValidF, 1'b0);

        // Streaming after reset.
        tick();
        rst_n = 1'b1; imem_gnt = 1'b1;
        @(negedge clk);
        chk("a_req", imem_req, 1'b1);
        chk("a_addr", imem_addr, 32'h100);
        chk("a_valid", InstrValidF, 1'b0);
        chk("a_instr", InstrF, NOP);
        chk("a_pcf", PCF, 32'h100);
        @(negedge clk);
        chk("b_addr", imem_addr, 32'h104);
        chk("b_pcf", PCF, 32'h100);
`ifdef FETCH_BYPASS_EN
        chk("b_valid", InstrValidF, 1'b1);
        chk("b_instr", InstrF, mdata(32'h100));
`else
        chk("b_valid", InstrValidF, 1'b0);
        chk("b_instr", InstrF, NOP);
`endif
        repeat (10) tick();
        if (grant_log.size() < 3) begin
            n_cmp++; n_err++;
            $display("FAIL grant_seq: got %0d grants expected at least 3", grant_log.size());
        end else begin
            chk("grant0", grant_log[0], 32'h100);
            chk("grant1", grant_log[1], 32'h104);
            chk("grant2", grant_log[2], 32'h108);
        end

        // Stall with a full queue: everything holds on the scoreboard head.
        StallF = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", imem_req, 1'b0);
            chk("stall_valid", InstrValidF, 1'b1);
            chk("stall_depth", exp_q.size(), 32'd2);
            if (exp_q.size() > 0) begin
                chk("stall_pcf", PCF, exp_q[0].pc);
                chk("stall_instr", InstrF, exp_q[0].data);
            end
        end
        tick();
        StallF = 1'b0;
        repeat (4) tick();

        // Grant held low: queue drains, then NOP at pc_q with no push.
        imem_gnt = 1'b0;
        repeat (5) tick();
        chk("gntlo_empty", exp_q.size(), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("gntlo_req", imem_req, 1'b1);
            chk("gntlo_addr", imem_addr, tb_pc);
            chk("gntlo_pcf", PCF, tb_pc);
            chk("gntlo_valid", InstrValidF, 1'b0);
            chk("gntlo_instr", InstrF, NOP);
        end

        // Redirect with two requests outstanding.
        tick();
        mem_hold = 1'b1; imem_gnt = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("full_req", imem_req, 1'b0);
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h203; mem_hold = 1'b0;
        exp_q.delete(); tb_pc = 32'h200;
        @(negedge clk);
        chk("redir_req", imem_req, 1'b0);
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        chk("redir_next_req", imem_req, 1'b1);
        chk("redir_next_addr", imem_addr, 32'h200);
        wait_valid("redir2", 32'h200);

        // Redirect coinciding with the only outstanding response.
        imem_gnt = 1'b0;
        repeat (6) tick();
        imem_gnt = 1'b1;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        exp_q.delete(); tb_pc = 32'h300;
        tick();
        PCSrcE = 1'b0;
        wait_valid("redir1", 32'h300);

        // Response latency for a lone fetch.
        imem_gnt = 1'b0;
        repeat (6) tick();
        x = tb_pc;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        @(negedge clk);
        chk("lat_pcf", PCF, x);
`ifdef FETCH_BYPASS_EN
        chk("lat_valid", InstrValidF, 1'b1);
        chk("lat_instr", InstrF, mdata(x));
`else
        chk("lat_valid", InstrValidF, 1'b0);
        chk("lat_instr", InstrF, NOP);
        @(negedge clk);
        chk("lat_valid_next", InstrValidF, 1'b1);
        chk("lat_instr_next", InstrF, mdata(x));
`endif
        repeat (6) tick();
        chk("leftover", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
